// File: rtl/i2c_cfg_sequencer_pkg.sv
// Shared definitions for the I2C sensor-configuration sequencer.
// The state encodings and the soft-reset register address live here.
package i2c_cfg_pkg;

    localparam int unsigned ST_W = 4;

    localparam logic [ST_W-1:0] PWR_WAIT     = 4'd0;
    localparam logic [ST_W-1:0] FETCH        = 4'd1;
    localparam logic [ST_W-1:0] DELAY        = 4'd2;
    localparam logic [ST_W-1:0] ISSUE        = 4'd3;
    localparam logic [ST_W-1:0] WAIT_RSP     = 4'd4;
    localparam logic [ST_W-1:0] VERIFY_ISSUE = 4'd5;
    localparam logic [ST_W-1:0] VERIFY_WAIT  = 4'd6;
    localparam logic [ST_W-1:0] NEXT         = 4'd7;
    localparam logic [ST_W-1:0] DONE         = 4'd8;
    localparam logic [ST_W-1:0] ERROR        = 4'd9;

    localparam logic [15:0] SOFT_RESET_ADDR = 16'h0103;

    // Soft-reset writes restart the sensor, so reading them back is meaningless
    function automatic logic is_soft_reset(input logic [15:0] addr);
        return addr == SOFT_RESET_ADDR;
    endfunction

endpackage

// File: rtl/i2c_cfg_sequencer_if.sv
// Request/response channel between the configuration sequencer and the
// byte-level I2C master.
interface i2c_cfg_sequencer_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_rd;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_nack;
    logic [DATA_W-1:0] rsp_rdata;

    // Sequencer side
    modport master (
        output req_valid, req_rd, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_nack, rsp_rdata
    );

    // I2C master side
    modport slave (
        input  req_valid, req_rd, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_nack, rsp_rdata
    );

endinterface

// File: rtl/i2c_cfg_sequencer_ms_tick_gen.sv
// Free-running millisecond tick: one-cycle pulse every CLK_FREQ_HZ/1000 clocks.
module ms_tick_gen #(
    parameter int unsigned CLK_FREQ_HZ = 24_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned DIV   = (CLK_FREQ_HZ / 1000 > 1) ? CLK_FREQ_HZ / 1000 : 2;
    localparam int unsigned CNT_W = $clog2(DIV);

    logic [CNT_W-1:0] cnt_q;

    // Divider counter and registered tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else if (cnt_q == CNT_W'(DIV - 1)) begin
            cnt_q <= '0;
            tick  <= 1'b1;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// Sensor-configuration sequencer: walks an {addr, data} register table and
// turns each entry into an I2C write, with power-up wait, delay entries,
// NACK retry and error reporting.
// Optional read-back verification is enabled with macro I2C_CFG_VERIFY_EN.
module i2c_cfg_sequencer
    import i2c_cfg_pkg::*;
#(
    parameter int unsigned       ADDR_W        = 16,
    parameter int unsigned       DATA_W        = 8,
    parameter int unsigned       IDX_W         = 9,
    parameter logic [ADDR_W-1:0] DELAY_MARK    = '1,
    parameter int unsigned       CLK_FREQ_HZ   = 24_000_000,
    parameter int unsigned       INIT_DELAY_MS = 20,
    parameter int unsigned       MAX_RETRY     = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [IDX_W-1:0]         lut_size,
    output logic [IDX_W-1:0]         lut_index,
    input  logic [ADDR_W+DATA_W-1:0] lut_data,
    i2c_cfg_sequencer_if.master      bus,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [IDX_W-1:0]         err_index
);

    localparam int unsigned PWR_W = (INIT_DELAY_MS > 0) ? $clog2(INIT_DELAY_MS + 1) : 1;
    // One spare bit so data+1 never wraps for an all-ones delay entry
    localparam int unsigned CNT_W = ((DATA_W > PWR_W) ? DATA_W : PWR_W) + 1;
    localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic [ST_W-1:0]   state_q,      state_d;
    logic [IDX_W-1:0]  lut_index_q,  lut_index_d;
    logic [ADDR_W-1:0] entry_addr_q, entry_addr_d;
    logic [DATA_W-1:0] entry_data_q, entry_data_d;
    logic [CNT_W-1:0]  ms_cnt_q,     ms_cnt_d;
    logic [RTY_W-1:0]  retry_q,      retry_d;
    logic              req_valid_q,  req_valid_d;
    logic [ADDR_W-1:0] req_addr_q,   req_addr_d;
    logic [DATA_W-1:0] req_wdata_q,  req_wdata_d;
    logic              busy_q,       busy_d;
    logic              done_q,       done_d;
    logic              error_q,      error_d;
    logic [IDX_W-1:0]  err_index_q,  err_index_d;
`ifdef I2C_CFG_VERIFY_EN
    logic              req_rd_q,     req_rd_d;
`endif

    logic              tick;
    logic [ADDR_W-1:0] lut_addr_c;
    logic [DATA_W-1:0] lut_wdata_c;
    logic              retry_full_c;
    logic              fail_c;

    assign lut_addr_c   = lut_data[ADDR_W+DATA_W-1 -: ADDR_W];
    assign lut_wdata_c  = lut_data[DATA_W-1:0];
    assign retry_full_c = (retry_q == RTY_W'(MAX_RETRY));

    ms_tick_gen #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ)
    ) u_ms_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        lut_index_d  = lut_index_q;
        entry_addr_d = entry_addr_q;
        entry_data_d = entry_data_q;
        ms_cnt_d     = ms_cnt_q;
        retry_d      = retry_q;
        req_valid_d  = req_valid_q;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;
        busy_d       = busy_q;
        done_d       = done_q;
        error_d      = error_q;
        err_index_d  = err_index_q;
        fail_c       = 1'b0;
`ifdef I2C_CFG_VERIFY_EN
        req_rd_d     = req_rd_q;
`endif

        case (state_q)
            PWR_WAIT: begin
                if (ms_cnt_q == CNT_W'(INIT_DELAY_MS)) begin
                    state_d  = FETCH;
                    ms_cnt_d = '0;
                end else if (tick) begin
                    ms_cnt_d = ms_cnt_q + CNT_W'(1);
                end
            end

            FETCH: begin
                entry_addr_d = lut_addr_c;
                entry_data_d = lut_wdata_c;
                ms_cnt_d     = '0;
                if (lut_index_q >= lut_size) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (lut_addr_c == DELAY_MARK) begin
                    state_d = DELAY;
                end else begin
                    state_d     = ISSUE;
                    req_valid_d = 1'b1;
                    req_addr_d  = lut_addr_c;
                    req_wdata_d = lut_wdata_c;
                end
            end

            // First tick after entry only arms the count, giving N..N+1 ms
            DELAY: begin
                if (entry_data_q == '0 ||
                    ms_cnt_q == CNT_W'(entry_data_q) + CNT_W'(1)) begin
                    state_d = NEXT;
                end else if (tick) begin
                    ms_cnt_d = ms_cnt_q + CNT_W'(1);
                end
            end

            ISSUE: begin
                if (req_valid_q && bus.req_ready) begin
                    req_valid_d = 1'b0;
                    state_d     = WAIT_RSP;
                end
            end

            WAIT_RSP: begin
                if (bus.rsp_valid) begin
                    if (bus.rsp_nack) begin
                        if (retry_full_c) begin
                            fail_c = 1'b1;
                        end else begin
                            retry_d     = retry_q + RTY_W'(1);
                            state_d     = ISSUE;
                            req_valid_d = 1'b1;
                            req_addr_d  = entry_addr_q;
                            req_wdata_d = entry_data_q;
                        end
                    end else begin
`ifdef I2C_CFG_VERIFY_EN
                        if (is_soft_reset(16'(entry_addr_q))) begin
                            state_d = NEXT;
                        end else begin
                            state_d     = VERIFY_ISSUE;
                            req_valid_d = 1'b1;
                            req_rd_d    = 1'b1;
                        end
`else
                        state_d = NEXT;
`endif
                    end
                end
            end

`ifdef I2C_CFG_VERIFY_EN
            VERIFY_ISSUE: begin
                if (req_valid_q && bus.req_ready) begin
                    req_valid_d = 1'b0;
                    req_rd_d    = 1'b0;
                    state_d     = VERIFY_WAIT;
                end
            end

            // A NACK or wrong read-back both cost one retry of the write
            VERIFY_WAIT: begin
                if (bus.rsp_valid) begin
                    if (bus.rsp_nack || bus.rsp_rdata != entry_data_q) begin
                        if (retry_full_c) begin
                            fail_c = 1'b1;
                        end else begin
                            retry_d     = retry_q + RTY_W'(1);
                            state_d     = ISSUE;
                            req_valid_d = 1'b1;
                            req_rd_d    = 1'b0;
                            req_addr_d  = entry_addr_q;
                            req_wdata_d = entry_data_q;
                        end
                    end else begin
                        state_d = NEXT;
                    end
                end
            end
`endif

            NEXT: begin
                lut_index_d = lut_index_q + IDX_W'(1);
                retry_d     = '0;
                state_d     = FETCH;
            end

            DONE, ERROR: begin
                if (start) begin
                    state_d     = FETCH;
                    lut_index_d = '0;
                    retry_d     = '0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    err_index_d = '0;
                end
            end

            default: begin
                state_d = PWR_WAIT;
            end
        endcase

        if (fail_c) begin
            state_d     = ERROR;
            busy_d      = 1'b0;
            error_d     = 1'b1;
            err_index_d = lut_index_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= PWR_WAIT;
            lut_index_q  <= '0;
            entry_addr_q <= '0;
            entry_data_q <= '0;
            ms_cnt_q     <= '0;
            retry_q      <= '0;
            req_valid_q  <= 1'b0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_index_q  <= '0;
        end else begin
            state_q      <= state_d;
            lut_index_q  <= lut_index_d;
            entry_addr_q <= entry_addr_d;
            entry_data_q <= entry_data_d;
            ms_cnt_q     <= ms_cnt_d;
            retry_q      <= retry_d;
            req_valid_q  <= req_valid_d;
            req_addr_q   <= req_addr_d;
            req_wdata_q  <= req_wdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            err_index_q  <= err_index_d;
        end
    end

`ifdef I2C_CFG_VERIFY_EN
    // Read/write select for the read-back request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_rd_q <= 1'b0;
        end else begin
            req_rd_q <= req_rd_d;
        end
    end

    assign bus.req_rd = req_rd_q;
`else
    assign bus.req_rd = 1'b0;
`endif

    assign bus.req_valid = req_valid_q;
    assign bus.req_addr  = req_addr_q;
    assign bus.req_wdata = req_wdata_q;
    assign lut_index     = lut_index_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign err_index     = err_index_q;

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Directed bench for i2c_cfg_sequencer with a behavioural I2C master.
// 1 ms = 100 cycles (CLK_FREQ_HZ = 100_000).
module tb_i2c_cfg_sequencer;

    localparam int unsigned IDX_W = 9;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [IDX_W-1:0] lut_size = '0;
    logic [IDX_W-1:0] lut_index;
    logic [23:0]      lut_data;
    logic             busy, done, error;
    logic [IDX_W-1:0] err_index;
    logic [23:0]      tbl [512];

    i2c_cfg_sequencer_if #(.ADDR_W(16), .DATA_W(8)) bus_if ();

    i2c_cfg_sequencer #(
        .ADDR_W        (16),
        .DATA_W        (8),
        .IDX_W         (IDX_W),
        .CLK_FREQ_HZ   (100_000),
        .INIT_DELAY_MS (20),
        .MAX_RETRY     (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .lut_size  (lut_size),
        .lut_index (lut_index),
        .lut_data  (lut_data),
        .bus       (bus_if.master),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_index (err_index)
    );

    assign lut_data = tbl[lut_index];

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    // Slave knobs and transaction log
    int          ready_delay = 0;
    int          rsp_lat     = 2;
    int          nack_idx    = -1;
    int          nack_left   = 0;
    logic [7:0]  rd_q [$];
    logic [15:0] log_addr  [64];
    logic [7:0]  log_wdata [64];
    logic        log_rd    [64];
    int          log_acc   [64];
    int          log_rsp   [64];
    int          n_log = 0;
    int          rel_cyc = 0;

    // Behavioural I2C master: accepts after ready_delay, answers after rsp_lat
    initial begin : slave
        int         hold_cnt;
        bit         pending;
        int         pend_cnt;
        logic       pend_nack;
        logic [7:0] pend_rdata;
        logic [7:0] last_wdata;
        hold_cnt = 0; pending = 0; pend_cnt = 0;
        pend_nack = 0; pend_rdata = 0; last_wdata = 0;
        bus_if.req_ready = 0; bus_if.rsp_valid = 0;
        bus_if.rsp_nack = 0;  bus_if.rsp_rdata = 0;
        forever begin
            @(negedge clk);
            bus_if.req_ready = 0;
            bus_if.rsp_valid = 0;
            bus_if.rsp_nack  = 0;
            if (!rst_n) begin
                pending  = 0;
                hold_cnt = 0;
            end else if (pending) begin
                if (pend_cnt == 0) begin
                    bus_if.rsp_valid = 1;
                    bus_if.rsp_nack  = pend_nack;
                    bus_if.rsp_rdata = pend_rdata;
                    pending = 0;
                    if (n_log > 0) log_rsp[n_log-1] = cyc;
                end else begin
                    pend_cnt--;
                end
            end else if (bus_if.req_valid) begin
                if (hold_cnt >= ready_delay) begin
                    bus_if.req_ready = 1;
                    hold_cnt = 0;
                    if (n_log < 64) begin
                        log_addr[n_log]  = bus_if.req_addr;
                        log_wdata[n_log] = bus_if.req_wdata;
                        log_rd[n_log]    = bus_if.req_rd;
                        log_acc[n_log]   = cyc;
                        n_log++;
                    end
                    pending  = 1;
                    pend_cnt = rsp_lat;
                    if (!bus_if.req_rd) begin
                        last_wdata = bus_if.req_wdata;
                        pend_nack  = (nack_left > 0) && (int'(lut_index) == nack_idx);
                        if (pend_nack) nack_left--;
                        pend_rdata = 8'h00;
                    end else begin
                        pend_nack = 0;
                        if (rd_q.size() > 0) pend_rdata = rd_q.pop_front();
                        else                 pend_rdata = last_wdata;
                    end
                end else begin
                    hold_cnt++;
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded 100000 cycles");
        $fatal(1, "watchdog");
    end

    task automatic load_three();
        tbl[0] = {16'h3001, 8'h07};
        tbl[1] = {16'h3002, 8'hc0};
        tbl[2] = {16'h0100, 8'h01};
        lut_size = 9'd3;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done || error) begin ok = 1; break; end
        end
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus_if.req_valid) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 512; i++) tbl[i] = '0;
        load_three();
        rst_n = 0;
        repeat (3) @(negedge clk);
        n_chk++; if (bus_if.req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b want 0", bus_if.req_valid); end
        n_chk++; if (bus_if.req_rd !== 1'b0) begin n_fail++; $display("FAIL reset_req_rd: got %b want 0", bus_if.req_rd); end
        n_chk++; if (bus_if.req_addr !== 16'h0 || bus_if.req_wdata !== 8'h0) begin n_fail++; $display("FAIL reset_payload: got %h/%h want 0000/00", bus_if.req_addr, bus_if.req_wdata); end
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b want 1", busy); end
        n_chk++; if (done !== 1'b0 || error !== 1'b0) begin n_fail++; $display("FAIL reset_done_error: got %b/%b want 0/0", done, error); end
        n_chk++; if (lut_index !== '0 || err_index !== '0) begin n_fail++; $display("FAIL reset_index: got %0d/%0d want 0/0", lut_index, err_index); end
        rst_n = 1;
        rel_cyc = cyc;
    endtask

    task automatic test_basic();
        bit ok;
        wait_idle(4000, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL basic_timeout: done never rose"); end
        n_chk++; if (n_log != 3) begin n_fail++; $display("FAIL basic_count: got %0d want 3", n_log); end
        n_chk++; if (log_acc[0] - rel_cyc < 1990 || log_acc[0] - rel_cyc > 2110) begin n_fail++; $display("FAIL basic_pwr_wait: got %0d cycles want 1990..2110", log_acc[0] - rel_cyc); end
        n_chk++; if ({log_addr[0], log_wdata[0]} !== 24'h300107) begin n_fail++; $display("FAIL basic_entry0: got %h%h want 300107", log_addr[0], log_wdata[0]); end
        n_chk++; if ({log_addr[1], log_wdata[1]} !== 24'h3002c0) begin n_fail++; $display("FAIL basic_entry1: got %h%h want 3002c0", log_addr[1], log_wdata[1]); end
        n_chk++; if ({log_addr[2], log_wdata[2]} !== 24'h010001) begin n_fail++; $display("FAIL basic_entry2: got %h%h want 010001", log_addr[2], log_wdata[2]); end
        n_chk++; if ((log_rd[0] | log_rd[1] | log_rd[2]) !== 1'b0) begin n_fail++; $display("FAIL basic_rd: got read request want writes only"); end
        n_chk++; if (log_acc[1] - log_rsp[0] != 3) begin n_fail++; $display("FAIL basic_overhead: got %0d cycles want 3", log_acc[1] - log_rsp[0]); end
        n_chk++; if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin n_fail++; $display("FAIL basic_status: got done=%b busy=%b error=%b want 1/0/0", done, busy, error); end
        n_chk++; if (lut_index !== 9'd3) begin n_fail++; $display("FAIL basic_index: got %0d want 3", lut_index); end
    endtask

    task automatic test_delay();
        bit ok;
        tbl[0] = {16'h3001, 8'h11};
        tbl[1] = {16'hffff, 8'h05};
        tbl[2] = {16'h3002, 8'h22};
        tbl[3] = {16'hffff, 8'h00};
        tbl[4] = {16'h3003, 8'h33};
        lut_size = 9'd5;
        n_log = 0;
        pulse_start();
        wait_idle(2000, ok);
        n_chk++; if (!ok || done !== 1'b1) begin n_fail++; $display("FAIL delay_done: got done=%b want 1", done); end
        n_chk++; if (n_log != 3) begin n_fail++; $display("FAIL delay_count: got %0d want 3", n_log); end
        n_chk++; if (log_acc[1] - log_rsp[0] < 500 || log_acc[1] - log_rsp[0] > 612) begin n_fail++; $display("FAIL delay_5ms: got %0d cycles want 500..612", log_acc[1] - log_rsp[0]); end
        n_chk++; if (log_acc[2] - log_rsp[1] < 4 || log_acc[2] - log_rsp[1] > 8) begin n_fail++; $display("FAIL delay_zero: got %0d cycles want 4..8", log_acc[2] - log_rsp[1]); end
        n_chk++; if (log_addr[2] !== 16'h3003 || log_wdata[2] !== 8'h33) begin n_fail++; $display("FAIL delay_last: got %h/%h want 3003/33", log_addr[2], log_wdata[2]); end
    endtask

    task automatic test_zero_size();
        bit ok;
        lut_size = '0;
        n_log = 0;
        pulse_start();
        wait_idle(10, ok);
        n_chk++; if (!ok || done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_done: got done=%b busy=%b want 1/0", done, busy); end
        repeat (5) @(negedge clk);
        n_chk++; if (n_log != 0) begin n_fail++; $display("FAIL zero_requests: got %0d want 0", n_log); end
    endtask

    task automatic test_nack();
        bit ok;
        bit addr_ok;
        load_three();
        nack_idx = 1; nack_left = 4;
        n_log = 0;
        pulse_start();
        wait_idle(1000, ok);
        n_chk++; if (!ok || error !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL nack_status: got error=%b done=%b busy=%b want 1/0/0", error, done, busy); end
        n_chk++; if (err_index !== 9'd1) begin n_fail++; $display("FAIL nack_err_index: got %0d want 1", err_index); end
        n_chk++; if (n_log != 5) begin n_fail++; $display("FAIL nack_attempts: got %0d requests want 5", n_log); end
        addr_ok = 1;
        for (int i = 1; i < 5; i++) if (log_addr[i] !== 16'h3002) addr_ok = 0;
        n_chk++; if (!addr_ok) begin n_fail++; $display("FAIL nack_retry_addr: got a retry not at 3002 want 3002 x4"); end
        repeat (300) @(negedge clk);
        n_chk++; if (n_log != 5 || bus_if.req_valid !== 1'b0) begin n_fail++; $display("FAIL nack_quiet: got %0d requests valid=%b want 5/0", n_log, bus_if.req_valid); end
        // Exactly MAX_RETRY NACKs still completes; restart from ERROR
        nack_left = 3;
        n_log = 0;
        pulse_start();
        n_chk++; if (error !== 1'b0 || err_index !== '0 || busy !== 1'b1) begin n_fail++; $display("FAIL nack_restart: got error=%b err_index=%0d busy=%b want 0/0/1", error, err_index, busy); end
        wait_idle(1000, ok);
        n_chk++; if (!ok || done !== 1'b1 || error !== 1'b0) begin n_fail++; $display("FAIL nack_recover: got done=%b error=%b want 1/0", done, error); end
        n_chk++; if (n_log != 6) begin n_fail++; $display("FAIL nack_recover_count: got %0d want 6", n_log); end
        nack_idx = -1; nack_left = 0;
    endtask

    task automatic test_ready_hold();
        bit ok;
        int bad;
        tbl[0] = {16'h3a5c, 8'h96};
        lut_size = 9'd1;
        ready_delay = 50;
        n_log = 0;
        pulse_start();
        wait_valid(20, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL hold_valid: req_valid never rose"); end
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus_if.req_valid !== 1'b1 || bus_if.req_addr !== 16'h3a5c || bus_if.req_wdata !== 8'h96) bad++;
            if (i == 10) start = 1;
            if (i == 11) start = 0;
            @(negedge clk);
        end
        n_chk++; if (bad != 0) begin n_fail++; $display("FAIL hold_stable: got %0d unstable cycles want 0", bad); end
        wait_idle(200, ok);
        n_chk++; if (!ok || n_log != 1) begin n_fail++; $display("FAIL hold_single: got %0d transfers want 1", n_log); end
        n_chk++; if (bus_if.req_valid !== 1'b0) begin n_fail++; $display("FAIL hold_drop: got req_valid=%b want 0", bus_if.req_valid); end
        ready_delay = 0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        load_three();
        ready_delay = 30;
        n_log = 0;
        pulse_start();
        wait_valid(20, ok);
        // Reset while the request is waiting for ready: valid must fall at once
        @(posedge clk); #2 rst_n = 0; #1;
        n_chk++; if (!ok || bus_if.req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_issue_async: got req_valid=%b want 0", bus_if.req_valid); end
        repeat (2) @(negedge clk);
        ready_delay = 0; rsp_lat = 20; n_log = 0;
        rst_n = 1; rel_cyc = cyc;
        ok = 0;
        for (int i = 0; i < 2500; i++) begin @(negedge clk); if (n_log > 0) begin ok = 1; break; end end
        n_chk++; if (!ok || log_addr[0] !== 16'h3001) begin n_fail++; $display("FAIL rst_first_addr: got %h want 3001", log_addr[0]); end
        repeat (5) @(negedge clk);
        @(posedge clk); #2 rst_n = 0; #1;
        n_chk++; if (bus_if.req_valid !== 1'b0 || lut_index !== '0 || busy !== 1'b1) begin n_fail++; $display("FAIL rst_wait_rsp: got valid=%b index=%0d busy=%b want 0/0/1", bus_if.req_valid, lut_index, busy); end
        repeat (2) @(negedge clk);
        rsp_lat = 2; n_log = 0;
        rst_n = 1; rel_cyc = cyc;
        wait_idle(4000, ok);
        n_chk++; if (!ok || n_log != 3 || log_addr[0] !== 16'h3001) begin n_fail++; $display("FAIL rst_rerun: got %0d requests first=%h want 3/3001", n_log, log_addr[0]); end
        n_chk++; if (log_acc[0] - rel_cyc < 1990 || log_acc[0] - rel_cyc > 2110) begin n_fail++; $display("FAIL rst_pwr_wait: got %0d cycles want 1990..2110", log_acc[0] - rel_cyc); end
    endtask

`ifdef I2C_CFG_VERIFY_EN
    task automatic test_verify();
        bit ok;
        tbl[0] = {16'h3e01, 8'h45};
        tbl[1] = {16'h0103, 8'h01};
        lut_size = 9'd2;
        rd_q.push_back(8'h44);
        n_log = 0;
        pulse_start();
        wait_idle(500, ok);
        n_chk++; if (!ok || done !== 1'b1) begin n_fail++; $display("FAIL verify_done: got done=%b want 1", done); end
        n_chk++; if (n_log != 5) begin n_fail++; $display("FAIL verify_count: got %0d want 5", n_log); end
        n_chk++; if ({log_rd[0], log_rd[1], log_rd[2], log_rd[3], log_rd[4]} !== 5'b01010) begin n_fail++; $display("FAIL verify_pattern: got %b%b%b%b%b want 01010", log_rd[0], log_rd[1], log_rd[2], log_rd[3], log_rd[4]); end
        n_chk++; if (log_addr[3] !== 16'h3e01 || log_addr[4] !== 16'h0103) begin n_fail++; $display("FAIL verify_addr: got %h/%h want 3e01/0103", log_addr[3], log_addr[4]); end
    endtask
`endif

    initial begin : main
        test_reset();
        test_basic();
        test_delay();
        test_zero_size();
        test_nack();
        test_ready_hold();
        test_reset_mid();
`ifdef I2C_CFG_VERIFY_EN
        test_verify();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_cfg_sequencer.md
# i2c_cfg_sequencer

Parametrised sensor-configuration sequencer for CMOS sensor bring-up. It walks a combinational register table of {address, data} entries, such as the SC2210 1920x1080 4-lane set, through a shared index/data/size interface. Each entry becomes a write request to the byte-level I2C master over a valid/ready handshake. Generalises the fixed 16/8-bit table walker with:
- configurable address and data widths;
- a power-up wait and in-table delay entries;
- NACK retry;
- error reporting;
- optional read-back verification.

## Interface
Parameters:
- ADDR_W, 16, register address width (8 or 16)
- DATA_W, 8, register data width (8 or 16)
- IDX_W, 9, table index width
- DELAY_MARK, all-ones of ADDR_W, address value that marks a delay entry
- CLK_FREQ_HZ, 24_000_000, clk frequency used to derive the 1 ms tick
- INIT_DELAY_MS, 20, wait after reset release before the first entry
- MAX_RETRY, 3, retries per entry after a NACK or verify mismatch

Ports:
- clk  in  1  system clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; re-runs the table from index 0
- lut_size  in  IDX_W  number of valid entries
- lut_index  out  IDX_W  current table index
- lut_data  in  ADDR_W+DATA_W  {addr, data}; combinational from lut_index
- req_valid  out  1  I2C request valid
- req_ready  in  1  I2C master accepts the request
- req_rd  out  1  1 = read, 0 = write
- req_addr  out  ADDR_W  register address
- req_wdata  out  DATA_W  write data
- rsp_valid  in  1  one-cycle transaction-complete pulse
- rsp_nack  in  1  qualified by rsp_valid; slave NACKed
- rsp_rdata  in  DATA_W  qualified by rsp_valid; read data
- busy  out  1  sequence in progress
- done  out  1  level; the table completed without error
- error  out  1  level; the retry budget was exhausted
- err_index  out  IDX_W  index of the failing entry

## Operation
State machine and transitions:
- **PWR_WAIT**: entered on reset release. Wait INIT_DELAY_MS tick counts, then go to FETCH.
- **FETCH**: register lut_data. If lut_index ≥ lut_size, go to DONE.
- **DELAY**: entered from FETCH when the addr field equals DELAY_MARK. Count data-field ms ticks, then go to NEXT. A data value of 0 gives zero ticks.
- **ISSUE**: entered from FETCH for any other entry. Drive req_* from the registered entry; move on when req_valid && req_ready.
- **WAIT_RSP**: wait for rsp_valid.
  - rsp_nack=1: retry_cnt++ and return to ISSUE. If retry_cnt == MAX_RETRY, go to ERROR instead.
  - Otherwise: go to NEXT.
- **NEXT**: lut_index++, retry_cnt cleared, return to FETCH.
- **DONE**: busy=0, done=1.
- **ERROR**: busy=0, error=1, err_index = failing index.

Rules:
- start is accepted only in DONE or ERROR. It clears done, error and err_index, sets lut_index to 0 and goes to FETCH; the power-up wait is not repeated. start in any other state is ignored.
- rsp_valid outside WAIT_RSP (or outside VERIFY_WAIT when verify is enabled) is ignored.
- lut_size = 0: PWR_WAIT, then FETCH, then DONE, with no requests issued.
- Entries are issued strictly in index order. Soft-reset and stream-on entries (0x0103, 0x0100) get no special handling; any settling time they need is provided by explicit delay entries in the table.

## Timing
- Reset values: lut_index=0, req_valid=0, req_rd=0, req_addr=0, req_wdata=0, busy=1 (in PWR_WAIT), done=0, error=0, err_index=0. The state is PWR_WAIT.
- Reset mid-operation drops req_valid immediately (asynchronously) and restarts from PWR_WAIT.
- All outputs are registered.
- Handshake:
  - req_valid and the request payload are held stable until the clk edge on which req_ready=1.
  - req_valid deasserts the following cycle.
  - At most one request is outstanding.
- Per write entry the sequencer adds 1 cycle (FETCH) + 1 cycle (ISSUE minimum) + 1 cycle (NEXT) on top of the master's latency.
- The ms tick is a free-running counter modulo CLK_FREQ_HZ/1000.
  - Its width is $clog2(CLK_FREQ_HZ/1000).
  - Delay counting starts at the first tick after entry, so the actual delay is N to N+1 ms.
- done and error are levels held until the next start or reset.

## Configuration
Macro: I2C_CFG_VERIFY_EN.
- **Defined**: after each successful write the sequencer goes to VERIFY_ISSUE, which issues req_rd=1 to the same address. VERIFY_WAIT then compares rsp_rdata with the written data.
  - A mismatch or NACK consumes one retry and returns to ISSUE (the write).
  - A match goes to NEXT.
  - Entries with address 0x0103 (soft reset) skip verification.
- **Undefined**: the VERIFY states are absent, req_rd is tied to 0, and rsp_rdata is unused.

## Structure
- Package i2c_cfg_pkg holds the state enum (PWR_WAIT, FETCH, DELAY, ISSUE, WAIT_RSP, VERIFY_ISSUE, VERIFY_WAIT, NEXT, DONE, ERROR) and the soft-reset address constant 0x0103.
- One sub-module, ms_tick_gen, parameterised by CLK_FREQ_HZ and producing a one-cycle tick every 1 ms.
- Existing fixed-table modules plug straight into the lut_index, lut_data and lut_size ports.

## Test plan
Every scenario runs with CLK_FREQ_HZ reduced to 100_000, so 1 ms = 100 cycles.
- Three-entry table {0x3001,0x07}, {0x3002,0xc0}, {0x0100,0x01} with an always-ACK master: after a 20 ms power-up wait, exactly 3 writes are issued in order, then done=1 and busy=0.
- Delay entry {0xFFFF,0x05} between two writes: the second req_valid rises 500 to 600 cycles after the first completes.
- Master NACKs index 1 four times: 4 attempts are seen, then error=1 and err_index=1; no further requests follow.
- req_ready held low for 50 cycles: req_addr and req_wdata stay stable throughout, and exactly one transfer is accepted.
- rst_n asserted during WAIT_RSP: req_valid=0 immediately; after release, PWR_WAIT runs and index 0 is reissued.
- With I2C_CFG_VERIFY_EN defined, read-back of {0x3e01,0x45} returns 0x44 once, then 0x45: write, read, write, read are seen, then NEXT.
